// File: rtl/collision_monitor_pkg.sv
// Shared draw-engine constants: frame-buffer layer codes and row width.
package draw_pkg;
  localparam logic [2:0] LAYER_IDLE  = 3'b000;
  localparam logic [2:0] LAYER_BACK  = 3'b001;
  localparam logic [2:0] LAYER_CLOUD = 3'b010;
  localparam logic [2:0] LAYER_OBST  = 3'b011;
  localparam logic [2:0] LAYER_FG    = 3'b100;
  localparam int         H_RES       = 640;
endpackage

// File: rtl/collision_monitor_if.sv
// Draw-engine write stream snooped by the collision monitor.
interface collision_monitor_if;
  logic [9:0] write_X;
  logic [9:0] write_Y;
  logic [2:0] write_which_layer;
  logic       write_en;
  logic       obstacle_px;
  logic       runner_px;

  modport master (
    output write_X, write_Y, write_which_layer,
    output write_en, obstacle_px, runner_px
  );
  modport slave (
    input write_X, write_Y, write_which_layer,
    input write_en, obstacle_px, runner_px
  );
endinterface

// File: rtl/collision_monitor_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge pulse.
module sync_edge (
  input  logic Clk50,
  input  logic Reset,
  input  logic d,
  output logic pulse
);
  logic s1, s2, s3;

  always_ff @(posedge Clk50) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;
endmodule

// File: rtl/collision_monitor.sv
// Per-row obstacle mask vs runner pixel overlap detector,
// with per-frame hit counting and a sticky Dead flag.
module collision_monitor
  import draw_pkg::*;
#(
  parameter int H_RES_P       = draw_pkg::H_RES,
  parameter int HIT_THRESHOLD = 4,
  parameter int CNT_W         = 8
) (
  input  logic             Clk50,
  input  logic             Reset,
  input  logic             frame_Clk,
  input  logic             detect_en,
  input  logic             clear_dead,
  collision_monitor_if.slave wr,
  output logic             hit,
  output logic [9:0]       hit_X,
  output logic [9:0]       hit_Y,
  output logic [CNT_W-1:0] frame_hits,
  output logic [CNT_W-1:0] last_frame_hits,
  output logic             Dead
);
  localparam logic [10:0]      XLIM = 11'(H_RES_P);
  localparam logic [CNT_W-1:0] THR  = CNT_W'(HIT_THRESHOLD);

  logic [H_RES_P-1:0] row_mask;
  logic [H_RES_P-1:0] mask_nxt;
  logic [9:0]         prev_Y;
  logic               fedge;
  logic               in_range;
  logic               row_change;
  logic               obst_wr;
  logic               run_wr;
  logic               is_hit;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_nxt;

  sync_edge u_frame_sync (
    .Clk50 (Clk50),
    .Reset (Reset),
    .d     (frame_Clk),
    .pulse (fedge)
  );

  assign in_range   = {1'b0, wr.write_X} < XLIM;
  assign row_change = wr.write_Y != prev_Y;
  assign obst_wr    = wr.write_en && wr.obstacle_px && in_range
                   && (wr.write_which_layer == LAYER_OBST);
  assign run_wr     = wr.write_en && wr.runner_px && in_range
                   && (wr.write_which_layer == LAYER_FG);
  // A row change means the mask still holds the previous row.
  assign is_hit     = run_wr && detect_en && !row_change
                   && row_mask[wr.write_X];

  always_comb begin
    mask_nxt = (row_change || fedge) ? '0 : row_mask;
    if (obst_wr)
      mask_nxt[wr.write_X] = 1'b1;
  end

  always_comb begin
    cnt_base = fedge ? '0 : frame_hits;
    cnt_nxt  = cnt_base;
    if (is_hit && cnt_base != '1)
      cnt_nxt = cnt_base + 1'b1;
  end

  always_ff @(posedge Clk50) begin
    if (Reset) begin
      row_mask        <= '0;
      prev_Y          <= '0;
      hit             <= 1'b0;
      hit_X           <= '0;
      hit_Y           <= '0;
      frame_hits      <= '0;
      last_frame_hits <= '0;
      Dead            <= 1'b0;
    end else if (clear_dead) begin
      row_mask        <= '0;
      prev_Y          <= wr.write_Y;
      hit             <= 1'b0;
      hit_X           <= '0;
      hit_Y           <= '0;
      frame_hits      <= '0;
      last_frame_hits <= '0;
      Dead            <= 1'b0;
    end else begin
      row_mask   <= mask_nxt;
      prev_Y     <= wr.write_Y;
      hit        <= is_hit;
      frame_hits <= cnt_nxt;
      if (is_hit) begin
        hit_X <= wr.write_X;
        hit_Y <= wr.write_Y;
      end
      if (fedge)
        last_frame_hits <= frame_hits;
      if (cnt_nxt >= THR)
        Dead <= 1'b1;
    end
  end
endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor with hand-computed expectations.
module tb_collision_monitor;
  import draw_pkg::*;

  logic       Clk50 = 1'b0;
  logic       Reset;
  logic       frame_Clk;
  logic       detect_en;
  logic       clear_dead;
  logic       hit;
  logic [9:0] hit_X, hit_Y;
  logic [7:0] frame_hits, last_frame_hits;
  logic       Dead;
  int         checks = 0;
  int         failures = 0;

  collision_monitor_if wr ();

  collision_monitor #(
    .HIT_THRESHOLD (4),
    .CNT_W         (8)
  ) dut (
    .Clk50           (Clk50),
    .Reset           (Reset),
    .frame_Clk       (frame_Clk),
    .detect_en       (detect_en),
    .clear_dead      (clear_dead),
    .wr              (wr.slave),
    .hit             (hit),
    .hit_X           (hit_X),
    .hit_Y           (hit_Y),
    .frame_hits      (frame_hits),
    .last_frame_hits (last_frame_hits),
    .Dead            (Dead)
  );

  always #5 Clk50 = ~Clk50;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk50);
    #1;
  endtask

  task automatic put(input logic [2:0] layer, input int x,
                     input int y, input logic ob, input logic rn);
    wr.write_which_layer = layer;
    wr.write_X           = 10'(x);
    wr.write_Y           = 10'(y);
    wr.write_en          = 1'b1;
    wr.obstacle_px       = ob;
    wr.runner_px         = rn;
    tick();
  endtask

  task automatic obst(input int x, input int y);
    put(LAYER_OBST, x, y, 1'b1, 1'b0);
  endtask

  task automatic run(input int x, input int y);
    put(LAYER_FG, x, y, 1'b0, 1'b1);
  endtask

  task automatic idle();
    wr.write_which_layer = LAYER_IDLE;
    wr.write_en          = 1'b0;
    wr.obstacle_px       = 1'b0;
    wr.runner_px         = 1'b0;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hit"}, 32'(hit), 0);
    chk({tag, "_fh"}, 32'(frame_hits), 0);
    chk({tag, "_lfh"}, 32'(last_frame_hits), 0);
    chk({tag, "_dead"}, 32'(Dead), 0);
  endtask

  initial begin
    int hits;
    Reset = 1'b1;
    frame_Clk = 1'b0;
    detect_en = 1'b1;
    clear_dead = 1'b0;
    wr.write_X = '0;
    wr.write_Y = '0;
    wr.write_which_layer = LAYER_IDLE;
    wr.write_en = 1'b0;
    wr.obstacle_px = 1'b0;
    wr.runner_px = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    chk("reset_hx", 32'(hit_X), 0);
    chk("reset_hy", 32'(hit_Y), 0);
    Reset = 1'b0;

    // Overlap of 2: obstacles 100..103, runners 102..105 on Y=200
    for (int x = 100; x <= 103; x++) obst(x, 200);
    hits = 0;
    for (int x = 102; x <= 105; x++) begin
      run(x, 200);
      hits += int'(hit);
    end
    chk("ov2_pulses", 32'(hits), 2);
    chk("ov2_hx", 32'(hit_X), 103);
    chk("ov2_hy", 32'(hit_Y), 200);
    chk("ov2_fh", 32'(frame_hits), 2);
    chk("ov2_dead", 32'(Dead), 0);

    // Third hit, then frame edge
    run(100, 200);
    chk("h3_hit", 32'(hit), 1);
    chk("h3_fh", 32'(frame_hits), 3);
    idle();
    frame_Clk = 1'b1;
    tick();
    tick();
    chk("fe_2nd_fh", 32'(frame_hits), 3);
    tick();
    chk("fe_3rd_lfh", 32'(last_frame_hits), 3);
    chk("fe_3rd_fh", 32'(frame_hits), 0);
    frame_Clk = 1'b0;
    repeat (3) idle();

    // Hit coinciding with the frame edge counts into the new frame
    obst(300, 200);
    idle();
    frame_Clk = 1'b1;
    tick();
    tick();
    run(300, 200);
    chk("fe_hit_hit", 32'(hit), 1);
    chk("fe_hit_fh", 32'(frame_hits), 1);
    chk("fe_hit_lfh", 32'(last_frame_hits), 0);
    frame_Clk = 1'b0;
    repeat (3) idle();

    clear_dead = 1'b1;
    idle();
    clear_dead = 1'b0;
    chk_zero("clr1");

    // Four overlaps reach the threshold
    for (int x = 400; x <= 403; x++) obst(x, 200);
    for (int x = 400; x <= 402; x++) run(x, 200);
    chk("thr3_dead", 32'(Dead), 0);
    run(403, 200);
    chk("thr4_dead", 32'(Dead), 1);
    chk("thr4_fh", 32'(frame_hits), 4);
    idle();
    frame_Clk = 1'b1;
    repeat (3) idle();
    frame_Clk = 1'b0;
    chk("thr_fe_lfh", 32'(last_frame_hits), 4);
    chk("thr_fe_fh", 32'(frame_hits), 0);
    chk("thr_fe_dead", 32'(Dead), 1);
    repeat (3) idle();
    chk("thr_sticky", 32'(Dead), 1);
    clear_dead = 1'b1;
    idle();
    clear_dead = 1'b0;
    chk_zero("clr2");

    // Detection disabled
    obst(500, 200);
    detect_en = 1'b0;
    run(500, 200);
    detect_en = 1'b1;
    chk("dis_hit", 32'(hit), 0);
    chk("dis_fh", 32'(frame_hits), 0);

    // Off-screen X ignored
    obst(700, 200);
    run(700, 200);
    chk("x700_hit", 32'(hit), 0);
    chk("x700_fh", 32'(frame_hits), 0);

    // Runner before obstacle at the same X
    run(70, 200);
    obst(70, 200);
    chk("order_hit", 32'(hit), 0);

    // Row change clears the mask
    obst(50, 10);
    run(50, 11);
    chk("row_hit", 32'(hit), 0);
    obst(60, 11);
    run(60, 11);
    chk("row_ctl_hit", 32'(hit), 1);
    chk("row_ctl_hx", 32'(hit_X), 60);
    chk("row_ctl_hy", 32'(hit_Y), 11);
    chk("row_ctl_fh", 32'(frame_hits), 1);

    // Reset mid-row
    obst(80, 11);
    Reset = 1'b1;
    idle();
    Reset = 1'b0;
    chk_zero("rst2");
    chk("rst2_hx", 32'(hit_X), 0);
    chk("rst2_hy", 32'(hit_Y), 0);
    run(80, 11);
    chk("rst2_run_hit", 32'(hit), 0);
    chk("rst2_run_fh", 32'(frame_hits), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
